// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that serialises set/reset requests from four
// requesters onto an 8-bit bank of SR flip-flops. Each operation runs
// IDLE -> GRANT (grant pulse) -> DRIVE (one strobe) -> IDLE (flag image update).
// All state advances on the falling edge of clk; clear is an asynchronous abort.
module sr_flag_arbiter (
  input  logic        clk,
  input  logic        clear,
  input  logic [3:0]  req,
  input  logic [3:0]  op,
  input  logic [11:0] idx,
  output logic [3:0]  gnt,
  output logic [7:0]  S,
  output logic [7:0]  R,
  output logic [7:0]  flags,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [7:0]  s_q, s_d;
  logic [7:0]  r_q, r_d;
  logic [7:0]  flags_q, flags_d;
  logic        op_q, op_d;
  logic [2:0]  idx_q, idx_d;

  // Per-requester view of the packed index bus.
  logic [2:0]  idx_arr [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_idx
      assign idx_arr[gi] = idx[3*gi +: 3];
    end
  endgenerate

  logic        found;
  logic [1:0]  win;

  // Round-robin search starting at ptr_q; first active requester wins.
  always_comb begin
    logic [1:0] cand;
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state and registered-output logic; strobes and grant default to zero
  // so every pulse is exactly one cycle wide.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = 4'b0000;
    s_d     = 8'h00;
    r_d     = 8'h00;
    flags_d = flags_q;
    op_d    = op_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          op_d    = op[win];
          idx_d   = idx_arr[win];
          ptr_d   = win + 2'd1;
        end
      end
      GRANT: begin
        state_d = DRIVE;
        if (op_q) begin
          s_d = 8'h01 << idx_q;
        end else begin
          r_d = 8'h01 << idx_q;
        end
      end
      DRIVE: begin
        state_d        = IDLE;
        flags_d[idx_q] = op_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Falling-edge state register; clear aborts any operation in flight.
  always_ff @(negedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      s_q     <= 8'h00;
      r_q     <= 8'h00;
      flags_q <= 8'h00;
      op_q    <= 1'b0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      flags_q <= flags_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
    end
  end

  assign gnt   = gnt_q;
  assign S     = s_q;
  assign R     = r_q;
  assign flags = flags_q;
  assign busy  = (state_q != IDLE);

endmodule
